scan_sequencer: RTL and testbench

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

---
 rtl/scan_pkg.sv | 20 ++
 rtl/dwell_counter.sv | 38 +++
 rtl/scan_sequencer.sv | 149 ++++++++++++++
 tb/tb_scan_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and constants for the channel scan sequencer.
package scan_pkg;

  localparam int unsigned CHAN_W    = 3;
  localparam int unsigned DWELL_W   = 8;
  localparam logic [CHAN_W-1:0] LAST_CHAN = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StBlank,
    StDone
  } scan_state_e;

  // A programmed dwell of zero behaves as a single-cycle dwell.
  function automatic logic [DWELL_W-1:0] eff_dwell(input logic [DWELL_W-1:0] d);
    return (d == '0) ? DWELL_W'(1) : d;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Loadable down-counter; tc_o is high while the count sits at zero.
module dwell_counter
  import scan_pkg::*;
#(
  parameter int unsigned Width = DWELL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == '0);

  // Load has priority; decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Channel scan sequencer driving a 3-to-8 decoder select bus.
// Optional feature: define SCAN_BLANK_EN to insert a blank (decoder disabled)
// cycle on every channel advance.
module scan_sequencer
  import scan_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic               sel_A,
  output logic               sel_B,
  output logic               sel_C,
  output logic               sel_E,
  output logic [CHAN_W-1:0]  chan,
  output logic               busy,
  output logic               done
);

  scan_state_e        state_q, state_d;
  logic [CHAN_W-1:0]  chan_q, chan_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               mode_q, mode_d;
  logic               sel_e_q, sel_e_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               cnt_load;
  logic [DWELL_W-1:0] cnt_load_val;
  logic               cnt_en;
  logic               cnt_tc;

  dwell_counter #(
    .Width(DWELL_W)
  ) u_dwell_counter (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cnt_load),
    .load_val_i(cnt_load_val),
    .en_i      (cnt_en),
    .tc_o      (cnt_tc)
  );

  // Next state and next registered outputs; the counter is loaded with
  // dwell-1 so terminal count lands on the last cycle of each channel.
  always_comb begin
    state_d      = state_q;
    chan_d       = chan_q;
    dwell_d      = dwell_q;
    mode_d       = mode_q;
    sel_e_d      = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = dwell_q - DWELL_W'(1);
    cnt_en       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          state_d      = StScan;
          chan_d       = '0;
          sel_e_d      = 1'b1;
          busy_d       = 1'b1;
          dwell_d      = eff_dwell(dwell);
          mode_d       = mode;
          cnt_load     = 1'b1;
          cnt_load_val = eff_dwell(dwell) - DWELL_W'(1);
        end
      end

      StScan: begin
        if (stop) begin
          state_d = StIdle;
        end else begin
          busy_d = 1'b1;
          if (!cnt_tc) begin
            sel_e_d = 1'b1;
            cnt_en  = 1'b1;
          end else if (chan_q == LAST_CHAN && mode_q) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            // 3-bit increment wraps 7 -> 0 for continuous mode.
            chan_d   = chan_q + CHAN_W'(1);
            cnt_load = 1'b1;
`ifdef SCAN_BLANK_EN
            state_d  = StBlank;
            sel_e_d  = 1'b0;
`else
            sel_e_d  = 1'b1;
`endif
          end
        end
      end

      StBlank: begin
        // Counter was reloaded on entry and holds here.
        if (stop) begin
          state_d = StIdle;
        end else begin
          state_d = StScan;
          sel_e_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      chan_q  <= '0;
      dwell_q <= DWELL_W'(1);
      mode_q  <= 1'b0;
      sel_e_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      dwell_q <= dwell_d;
      mode_q  <= mode_d;
      sel_e_q <= sel_e_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sel_B = chan_q[0];
  assign sel_A = chan_q[1];
  assign sel_C = chan_q[2];
  assign chan  = chan_q;
  assign sel_E = sel_e_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer: a per-run expected trace is queued
// when each scan is launched; a monitor pops one entry per busy cycle.
module tb_scan_sequencer;

`ifdef SCAN_BLANK_EN
  localparam bit Blank = 1'b1;
`else
  localparam bit Blank = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, stop, mode;
  logic [7:0] dwell;
  logic       sel_A, sel_B, sel_C, sel_E, busy, done;
  logic [2:0] chan;

  typedef struct packed {
    logic [2:0] chan;
    logic       sel_e;
    logic       done;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  scan_sequencer dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .stop (stop),
    .mode (mode),
    .dwell(dwell),
    .sel_A(sel_A),
    .sel_B(sel_B),
    .sel_C(sel_C),
    .sel_E(sel_E),
    .chan (chan),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every busy cycle consumes one expected observation.
  always @(posedge clk) begin
    obs_t       e;
    obs_t       got;
    logic [7:0] dec, exp_dec;
    #1;
    if (mon_en && !rst) begin
      dec = sel_E ? (8'd1 << {sel_C, sel_A, sel_B}) : 8'd0;
      if (busy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_busy", int'(busy), 0);
        end else begin
          e       = exp_q.pop_front();
          got     = '{chan: chan, sel_e: sel_E, done: done};
          exp_dec = e.sel_e ? (8'd1 << e.chan) : 8'd0;
          check("scan_obs", int'(got), int'(e));
          check("decoder", int'(dec), int'(exp_dec));
        end
      end else begin
        check("idle_outputs", int'({done, sel_E, dec}), 0);
      end
    end
  end

  // Reference trace: dwell cycles per channel, optional blank on advance,
  // DONE after channel 7 in single-pass mode; stop at busy index k cuts it.
  task automatic run_scan(input logic [7:0] d, input logic m, input int k);
    obs_t q[$];
    int   deff = (d == 0) ? 1 : int'(d);
    int   ch   = 0;
    bit   fin  = 1'b0;
    int   len;
    logic [2:0] last;
    while (!fin && q.size() <= k && q.size() < 2000) begin
      for (int j = 0; j < deff; j++) q.push_back('{chan: 3'(ch), sel_e: 1'b1, done: 1'b0});
      if (ch == 7 && m) begin
        q.push_back('{chan: 3'd7, sel_e: 1'b0, done: 1'b1});
        fin = 1'b1;
      end else begin
        ch = (ch + 1) % 8;
        if (Blank) q.push_back('{chan: 3'(ch), sel_e: 1'b0, done: 1'b0});
      end
    end
    while (q.size() > k + 1) void'(q.pop_back());
    len  = q.size();
    last = q[len-1].chan;
    foreach (q[i]) exp_q.push_back(q[i]);

    @(negedge clk);
    start = 1'b1; stop = 1'b0; dwell = d; mode = m;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      // Inputs other than stop must be ignored while busy.
      start = 1'($urandom);
      dwell = 8'($urandom);
      mode  = 1'($urandom);
      stop  = (i == k);
    end
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("end_busy", int'(busy), 0);
    check("end_sel_e", int'(sel_E), 0);
    check("end_done", int'(done), 0);
    check("end_chan_hold", int'(chan), int'(last));
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; dwell = 8'd0;
    repeat (2) @(negedge clk);
    check("rst_chan", int'(chan), 0);
    check("rst_sel", int'({sel_C, sel_A, sel_B}), 0);
    check("rst_sel_e", int'(sel_E), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Single pass, dwell 3.
    run_scan(8'd3, 1'b1, 100000);
    // Continuous, dwell 0 treated as 1, several wraps then stop.
    run_scan(8'd0, 1'b0, 40);
    // Stop during channel 4 of a continuous scan at dwell 2.
    run_scan(8'd2, 1'b0, Blank ? 12 : 8);
    // Dwell 2 must persist despite mid-scan dwell changes.
    run_scan(8'd2, 1'b1, 100000);

    // start together with stop in IDLE stays idle.
    @(negedge clk);
    start = 1'b1; stop = 1'b1; dwell = 8'd5;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("start_stop_idle", int'(busy), 0);
    @(negedge clk);
    check("start_stop_idle2", int'(busy), 0);

    for (int t = 0; t < 20; t++) begin
      logic       m;
      logic [7:0] d;
      int         k;
      m = 1'($urandom);
      d = 8'($urandom_range(0, 4));
      k = m ? int'($urandom_range(0, 80)) : int'($urandom_range(0, 60));
      run_scan(d, m, k);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset in mid-scan at channel 5.
    mon_en = 1'b0;
    @(negedge clk);
    start = 1'b1; dwell = 8'd2; mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    begin
      int n = 0;
      while (!(busy && chan == 3'd5) && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("reach_chan5", int'(busy && chan == 3'd5), 1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_chan", int'(chan), 0);
    check("midrst_sel_e", int'(sel_E), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    mon_en = 1'b1;

    // Operation after mid-scan reset.
    run_scan(8'd1, 1'b1, 100000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d failures %0d",
             n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
